car_parking_ctrl: RTL and testbench

- Gate controller for a single-lane car park entrance.
- An entry sensor starts a password check. A correct 2-bit code opens the gate (green). A wrong code holds it closed (red).
- The exit sensor marks that the car has passed. Entry and exit sensors active together signal tailgating and stop the gate.
- Drives two LEDs and two 7-segment digits. Sits between the gate sensors/keypad and the gate actuator/display.

---
 rtl/car_parking_pkg.sv | 23 ++
 rtl/car_parking_display.sv | 41 ++++
 rtl/car_parking_ctrl.sv | 145 ++++++++++++++
 tb/tb_car_parking_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/car_parking_pkg.sv
// Shared types and 7-segment glyphs for the car park entrance controller.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package car_parking_pkg;

  typedef enum logic [2:0] {
    StIdle         = 3'd0,
    StWaitPassword = 3'd1,
    StWrongPass    = 3'd2,
    StRightPass    = 3'd3,
    StStop         = 3'd4
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_G     = 7'b0000010;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_U     = 7'b1000001;

endpackage

// File: rtl/car_parking_display.sv
// Combinational state -> two-digit 7-segment decoder; the parent registers the result.
module car_parking_display
  import car_parking_pkg::*;
(
  input  state_e     state,
  input  logic       full,
  output logic [6:0] hex_1,
  output logic [6:0] hex_2
);

  always_comb begin
    hex_1 = SEG_BLANK;
    hex_2 = SEG_BLANK;
    case (state)
      StIdle: begin
        if (full) begin
          hex_1 = SEG_F;
          hex_2 = SEG_U;
        end
      end
      StWaitPassword: begin
        hex_1 = SEG_E;
        hex_2 = SEG_N;
      end
      StWrongPass: begin
        hex_1 = SEG_E;
        hex_2 = SEG_E;
      end
      StRightPass: begin
        hex_1 = SEG_G;
        hex_2 = SEG_O;
      end
      StStop: begin
        hex_1 = SEG_S;
        hex_2 = SEG_P;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/car_parking_ctrl.sv
// Car park entrance gate controller: password check, gate LEDs and "En/EE/GO/SP" display.
// Optional OCCUPANCY_COUNT_EN adds a saturating car counter with count/full ports.
module car_parking_ctrl
  import car_parking_pkg::*;
#(
  parameter logic [1:0]  PASSWORD    = 2'b01,
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned CAPACITY    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sen_entry,
  input  logic       sen_exit,
  input  logic [1:0] password,
  output logic       green_led,
  output logic       red_led,
  output logic [6:0] hex_1,
  output logic [6:0] hex_2
`ifdef OCCUPANCY_COUNT_EN
  ,
  output logic [$clog2(CAPACITY+1)-1:0] count,
  output logic                          full
`endif
);

  if (WAIT_CYCLES < 1 || CAPACITY < 1) begin : g_bad_param
    $error("car_parking_ctrl: WAIT_CYCLES and CAPACITY must be at least 1");
  end

  localparam int unsigned WaitW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e             state_q, state_d;
  state_e             prev_q;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               wait_last;
  logic               pw_ok;
  logic               full_w;
  logic               green_q, green_d;
  logic               red_q, red_d;
  logic [6:0]         hex_1_q, hex_2_q;
  logic [6:0]         hex_1_d, hex_2_d;

  assign pw_ok     = (password == PASSWORD);
  assign wait_last = (wait_q == WaitW'(WAIT_CYCLES - 1));

`ifdef OCCUPANCY_COUNT_EN
  localparam int unsigned CntW = $clog2(CAPACITY + 1);

  logic [CntW-1:0] count_q;

  assign full_w = (count_q == CntW'(CAPACITY));

  // A car is counted in when it leaves the gate area (RIGHT_PASS -> IDLE).
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (state_q == StRightPass && state_d == StIdle && !full_w) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;
  assign full  = full_w;
`else
  assign full_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      StIdle: begin
        if (sen_entry && !full_w) state_d = StWaitPassword;
      end
      StWaitPassword: begin
        if (wait_last) begin
          state_d = pw_ok ? StRightPass : StWrongPass;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWrongPass: begin
        if (pw_ok) state_d = StRightPass;
      end
      StRightPass: begin
        // Both sensors together means a second car is tailgating.
        if (sen_entry && sen_exit) begin
          state_d = StStop;
        end else if (sen_exit) begin
          state_d = StIdle;
        end
      end
      StStop: begin
        if (pw_ok) state_d = StRightPass;
      end
      default: state_d = StIdle;
    endcase
  end

  // Blinking LEDs start lit on the first output cycle of a state, then alternate.
  always_comb begin
    green_d = 1'b0;
    red_d   = 1'b0;
    case (state_q)
      StIdle:                  red_d   = full_w;
      StWaitPassword:          red_d   = 1'b1;
      StWrongPass, StStop:     red_d   = (prev_q == state_q) ? ~red_q : 1'b1;
      StRightPass:             green_d = (prev_q == state_q) ? ~green_q : 1'b1;
      default: ;
    endcase
  end

  car_parking_display u_display (
    .state (state_q),
    .full  (full_w),
    .hex_1 (hex_1_d),
    .hex_2 (hex_2_d)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      prev_q  <= StIdle;
      wait_q  <= '0;
      green_q <= 1'b0;
      red_q   <= 1'b0;
      hex_1_q <= SEG_BLANK;
      hex_2_q <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      prev_q  <= state_q;
      wait_q  <= wait_d;
      green_q <= green_d;
      red_q   <= red_d;
      hex_1_q <= hex_1_d;
      hex_2_q <= hex_2_d;
    end
  end

  assign green_led = green_q;
  assign red_led   = red_q;
  assign hex_1     = hex_1_q;
  assign hex_2     = hex_2_q;

endmodule

// File: tb/tb_car_parking_ctrl.sv
// Bench for car_parking_ctrl: directed scenarios then random sensor/keypad/reset traffic,
// checked every cycle against a mode/age reference model.
module tb_car_parking_ctrl;

  localparam logic [1:0] PW    = 2'b01;
  localparam int         WAITC = 3;
  localparam int         CAP   = 8;
`ifdef OCCUPANCY_COUNT_EN
  localparam bit         OCC   = 1'b1;
`else
  localparam bit         OCC   = 1'b0;
`endif

  // Model modes
  localparam int MIdle  = 0;
  localparam int MWait  = 1;
  localparam int MWrong = 2;
  localparam int MRight = 3;
  localparam int MStop  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sen_entry = 1'b0;
  logic       sen_exit = 1'b0;
  logic [1:0] password = 2'b00;
  logic       green_led, red_led;
  logic [6:0] hex_1, hex_2;
`ifdef OCCUPANCY_COUNT_EN
  logic [3:0] count;
  logic       full;
`endif

  car_parking_ctrl #(
    .PASSWORD    (PW),
    .WAIT_CYCLES (WAITC),
    .CAPACITY    (CAP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sen_entry (sen_entry),
    .sen_exit  (sen_exit),
    .password  (password),
    .green_led (green_led),
    .red_led   (red_led),
    .hex_1     (hex_1),
    .hex_2     (hex_2)
`ifdef OCCUPANCY_COUNT_EN
    ,
    .count     (count),
    .full      (full)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // mode: current controller situation; age: edges spent in it; cars: occupancy
  int          mode = MIdle;
  int          age  = 0;
  int          cars = 0;
  logic [15:0] exp_out = 16'h3FFF;

  // Expected {green, red, hex_1, hex_2} shown one edge after entering a mode with this age.
  function automatic logic [15:0] expect_out(int m, int a, int c);
    logic blink;
    blink = ((a % 2) == 0);
    case (m)
      MIdle:   return (OCC && c == CAP) ? {2'b01, 7'b0001110, 7'b1000001}
                                        : {2'b00, 7'b1111111, 7'b1111111};
      MWait:   return {2'b01, 7'b0000110, 7'b0101011};
      MWrong:  return {1'b0, blink, 7'b0000110, 7'b0000110};
      MRight:  return {blink, 1'b0, 7'b0000010, 7'b1000000};
      MStop:   return {1'b0, blink, 7'b0010010, 7'b0001100};
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic model_edge(input logic e, input logic x, input logic [1:0] pw);
    int nxt;
    exp_out = expect_out(mode, age, cars);
    nxt = mode;
    case (mode)
      MIdle:  if (e && !(OCC && cars == CAP)) nxt = MWait;
      MWait:  if (age == WAITC - 1) nxt = (pw == PW) ? MRight : MWrong;
      MWrong: if (pw == PW) nxt = MRight;
      MRight: begin
        if (e && x) nxt = MStop;
        else if (x) nxt = MIdle;
      end
      MStop:  if (pw == PW) nxt = MRight;
      default: nxt = MIdle;
    endcase
    if (OCC && mode == MRight && nxt == MIdle && cars < CAP) cars++;
    age  = (nxt == mode) ? age + 1 : 0;
    mode = nxt;
  endtask

  task automatic step(input logic rst_n, input logic e, input logic x, input logic [1:0] pw);
    logic [15:0] obs;
    @(negedge clk);
    reset     = rst_n;
    sen_entry = e;
    sen_exit  = x;
    password  = pw;
    @(posedge clk);
    if (!rst_n) begin
      mode    = MIdle;
      age     = 0;
      cars    = 0;
      exp_out = 16'h3FFF;
    end else begin
      model_edge(e, x, pw);
    end
    #1;
    obs = {green_led, red_led, hex_1, hex_2};
    total++;
    assert (obs === exp_out) else begin
      bad++;
      $error("FAIL outputs{g,r,h1,h2} mode=%0d age=%0d obs=%h exp=%h", mode, age, obs, exp_out);
    end
`ifdef OCCUPANCY_COUNT_EN
    total++;
    assert (count === 4'(cars)) else begin
      bad++;
      $error("FAIL count obs=%0d exp=%0d", count, cars);
    end
    total++;
    assert (full === (cars == CAP)) else begin
      bad++;
      $error("FAIL full obs=%b exp=%b", full, (cars == CAP));
    end
`endif
  endtask

  initial begin
    // Reset held for 5 cycles
    repeat (5) step(1'b0, 1'b0, 1'b0, 2'b00);
    total++;
    assert ({green_led, red_led, hex_1, hex_2} === 16'h3FFF) else begin
      bad++;
      $error("FAIL reset_values obs=%h exp=%h", {green_led, red_led, hex_1, hex_2}, 16'h3FFF);
    end

    // Wrong code: En for 3 cycles, then EE with blinking red
    repeat (50) step(1'b1, 1'b1, 1'b0, 2'b00);
    // Correct code recovers to GO
    repeat (4) step(1'b1, 1'b0, 1'b0, PW);
    // Car passes
    step(1'b1, 1'b0, 1'b1, 2'b00);
    repeat (2) step(1'b1, 1'b0, 1'b0, 2'b00);

    // Right code straight from the keypad
    step(1'b1, 1'b1, 1'b0, PW);
    repeat (6) step(1'b1, 1'b0, 1'b0, PW);
    // Tailgate -> SP, then code -> GO
    step(1'b1, 1'b1, 1'b1, 2'b00);
    repeat (4) step(1'b1, 1'b0, 1'b0, 2'b10);
    step(1'b1, 1'b0, 1'b0, PW);
    repeat (3) step(1'b1, 1'b0, 1'b0, 2'b00);
    step(1'b1, 1'b0, 1'b1, 2'b00);

    // Reset in the middle of WRONG_PASS
    step(1'b1, 1'b1, 1'b0, 2'b11);
    repeat (6) step(1'b1, 1'b0, 1'b0, 2'b11);
    step(1'b0, 1'b0, 1'b0, 2'b11);
    repeat (3) step(1'b1, 1'b0, 1'b0, 2'b11);

    // Random traffic with rare resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
